pic_host_ctrl: RTL

CPU-side bus master for the 8259-compatible `PIC` block. It performs the initialization sequence (ICW1, ICW2, optional ICW3, optional ICW4, then OCW1) over the PIC's `cs`/`wr`/`rd`/`A0`/data bus. It answers `INT` with the two-pulse `INTA` acknowledge, captures the interrupt vector, and issues non-specific EOI and register-read (IRR/ISR/IMR) cycles on request. It replaces hand-written testbench stimulus and sits between a host core and `PIC` in system-level builds.

---
 rtl/pic_host_pkg.sv | 41 ++++
 rtl/pic_host_if.sv | 24 ++
 rtl/pic_bus_cycle.sv | 117 +++++++++++
 rtl/pic_host_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_host_pkg.sv
// rtl/pic_host_pkg.sv - shared types and constants for the 8259 host controller
package pic_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ICW1,
    ST_ICW2,
    ST_ICW3,
    ST_ICW4,
    ST_OCW1,
    ST_READY,
    ST_ACK1,
    ST_ACK2,
    ST_EOI,
    ST_OCW3,
    ST_RDREG
  } hostState_e;

  typedef enum logic [1:0] {
    BUS_WR,
    BUS_RD,
    BUS_INTA
  } busKind_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD,
    PH_GAP
  } busPhase_e;

  localparam logic [7:0] OCW2_NS_EOI = 8'h20;
  localparam logic [7:0] OCW3_RD_IRR = 8'h0A;
  localparam logic [7:0] OCW3_RD_ISR = 8'h0B;

  localparam logic [1:0] RD_SEL_IRR = 2'd0;
  localparam logic [1:0] RD_SEL_ISR = 2'd1;
  localparam logic [1:0] RD_SEL_IMR = 2'd2;

endpackage

// File: rtl/pic_host_if.sv
// rtl/pic_host_if.sv - PIC-side bus bundle between host controller and 8259
interface pic_host_if;

  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       inta_n;
  logic       a0;
  logic [7:0] dout;
  logic       dout_oe;
  logic [7:0] din;
  logic       pic_int;

  modport master (
    output cs_n, wr_n, rd_n, inta_n, a0, dout, dout_oe,
    input  din, pic_int
  );

  modport slave (
    input  cs_n, wr_n, rd_n, inta_n, a0, dout, dout_oe,
    output din, pic_int
  );

endinterface

// File: rtl/pic_bus_cycle.sv
// rtl/pic_bus_cycle.sv - one PIC bus cycle (write, read or INTA pulse) with strobe and gap timing
module pic_bus_cycle
  import pic_host_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int GAP_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  busKind_e   goKind,
  input  logic       goA0,
  input  logic [7:0] goData,
  input  logic [7:0] din,
  output logic       csN,
  output logic       wrN,
  output logic       rdN,
  output logic       intaN,
  output logic       a0,
  output logic [7:0] dout,
  output logic       doutOe,
  output logic       busy,
  output logic       done,
  output logic [7:0] captured
);

  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYC - 1);

  busPhase_e  phase, phaseNext;
  logic [7:0] cnt, cntNext;
  busKind_e   kind;
  logic       a0Reg;
  logic [7:0] dataReg;
  logic       accept;
  logic       inAddr;

  // Phase sequencing; a new go is taken when idle or on the last gap cycle so back-to-back cycles keep exactly GAP_CYC
  always_comb begin
    phaseNext = phase;
    cntNext   = cnt + 8'd1;
    done      = 1'b0;
    accept    = 1'b0;
    case (phase)
      PH_IDLE: begin
        cntNext = 8'd0;
        accept  = go;
      end
      PH_SETUP: begin
        phaseNext = PH_STROBE;
        cntNext   = 8'd0;
      end
      PH_STROBE: begin
        if (cnt == STROBE_LAST) begin
          cntNext   = 8'd0;
          phaseNext = (kind == BUS_INTA) ? PH_GAP : PH_HOLD;
        end
      end
      PH_HOLD: begin
        phaseNext = PH_GAP;
        cntNext   = 8'd0;
      end
      PH_GAP: begin
        if (cnt == GAP_LAST) begin
          done      = 1'b1;
          cntNext   = 8'd0;
          accept    = go;
          phaseNext = PH_IDLE;
        end
      end
      default: begin
        phaseNext = PH_IDLE;
        cntNext   = 8'd0;
      end
    endcase
    if (accept) begin
      phaseNext = (goKind == BUS_INTA) ? PH_STROBE : PH_SETUP;
    end
  end

  // Phase register, latched cycle parameters and read capture on the last low strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_IDLE;
      cnt      <= 8'd0;
      kind     <= BUS_WR;
      a0Reg    <= 1'b0;
      dataReg  <= 8'h00;
      captured <= 8'h00;
    end else begin
      phase <= phaseNext;
      cnt   <= cntNext;
      if (accept) begin
        kind    <= goKind;
        a0Reg   <= goA0;
        dataReg <= goData;
      end
      if (phase == PH_STROBE && cnt == STROBE_LAST && kind != BUS_WR) begin
        captured <= din;
      end
    end
  end

  // Bus pins decoded from the phase so reset releases every strobe immediately
  always_comb begin
    inAddr = (phase == PH_SETUP || phase == PH_STROBE || phase == PH_HOLD) && (kind != BUS_INTA);
    csN    = !inAddr;
    wrN    = !(phase == PH_STROBE && kind == BUS_WR);
    rdN    = !(phase == PH_STROBE && kind == BUS_RD);
    intaN  = !(phase == PH_STROBE && kind == BUS_INTA);
    a0     = inAddr & a0Reg;
    dout   = dataReg;
    doutOe = inAddr && (kind == BUS_WR);
    busy   = (phase != PH_IDLE);
  end

endmodule

// File: rtl/pic_host_ctrl.sv
// rtl/pic_host_ctrl.sv - host-side 8259 master: init sequence, INTA acknowledge, EOI and register reads
module pic_host_ctrl
  import pic_host_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int GAP_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  pic_host_if.master pic,
  input  logic       start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       eoi_req,
  input  logic       rd_req,
  input  logic [1:0] rd_sel,
  output logic       init_done,
  output logic       busy,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic       rdata_valid,
  output logic [7:0] rdata
);

  hostState_e state, stateNext;

  logic       cfgSngl, cfgIc4;
  logic [7:0] cfgIcw2, cfgIcw3, cfgIcw4, cfgOcw1;
  logic       autoEoi;
  logic       intMeta, intS;
  logic       eoiPend, rdPend;
  logic [1:0] rdSelReg;

  logic       go, goA0;
  busKind_e   goKind;
  logic [7:0] goData;
  logic       busDone;
  logic [7:0] captured;

  logic startInit, grantEoi, grantRd, endInit, endVec, endRd;

  assign autoEoi = cfgIc4 & cfgIcw4[1];

  pic_bus_cycle #(
    .STROBE_CYC(STROBE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_bus (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .goKind  (goKind),
    .goA0    (goA0),
    .goData  (goData),
    .din     (pic.din),
    .csN     (pic.cs_n),
    .wrN     (pic.wr_n),
    .rdN     (pic.rd_n),
    .intaN   (pic.inta_n),
    .a0      (pic.a0),
    .dout    (pic.dout),
    .doutOe  (pic.dout_oe),
    .busy    (busy),
    .done    (busDone),
    .captured(captured)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Sequencing: each transition into a bus state launches that state's cycle
  always_comb begin
    stateNext = state;
    go        = 1'b0;
    goKind    = BUS_WR;
    goA0      = 1'b0;
    goData    = 8'h00;
    startInit = 1'b0;
    grantEoi  = 1'b0;
    grantRd   = 1'b0;
    endInit   = 1'b0;
    endVec    = 1'b0;
    endRd     = 1'b0;
    case (state)
      ST_IDLE, ST_READY: begin
        if (start) begin
          startInit = 1'b1;
          go        = 1'b1;
          goData    = icw1;
          stateNext = ST_ICW1;
        end else if (state == ST_READY) begin
          if (eoiPend) begin
            grantEoi  = 1'b1;
            go        = 1'b1;
            goData    = OCW2_NS_EOI;
            stateNext = ST_EOI;
          end else if (intS) begin
            go        = 1'b1;
            goKind    = BUS_INTA;
            stateNext = ST_ACK1;
          end else if (rdPend) begin
            grantRd = 1'b1;
            go      = 1'b1;
            if (rdSelReg == RD_SEL_IMR) begin
              goKind    = BUS_RD;
              goA0      = 1'b1;
              stateNext = ST_RDREG;
            end else begin
              goData    = (rdSelReg == RD_SEL_ISR) ? OCW3_RD_ISR : OCW3_RD_IRR;
              stateNext = ST_OCW3;
            end
          end
        end
      end
      ST_ICW1: begin
        if (busDone) begin
          go        = 1'b1;
          goA0      = 1'b1;
          goData    = cfgIcw2;
          stateNext = ST_ICW2;
        end
      end
      ST_ICW2, ST_ICW3: begin
        if (busDone) begin
          go   = 1'b1;
          goA0 = 1'b1;
          if (state == ST_ICW2 && !cfgSngl) begin
            goData    = cfgIcw3;
            stateNext = ST_ICW3;
          end else if (cfgIc4) begin
            goData    = cfgIcw4;
            stateNext = ST_ICW4;
          end else begin
            goData    = cfgOcw1;
            stateNext = ST_OCW1;
          end
        end
      end
      ST_ICW4: begin
        if (busDone) begin
          go        = 1'b1;
          goA0      = 1'b1;
          goData    = cfgOcw1;
          stateNext = ST_OCW1;
        end
      end
      ST_OCW1: begin
        if (busDone) begin
          endInit   = 1'b1;
          stateNext = ST_READY;
        end
      end
      ST_ACK1: begin
        if (busDone) begin
          go        = 1'b1;
          goKind    = BUS_INTA;
          stateNext = ST_ACK2;
        end
      end
      ST_ACK2: begin
        if (busDone) begin
          endVec    = 1'b1;
          stateNext = ST_READY;
        end
      end
      ST_EOI: begin
        if (busDone) stateNext = ST_READY;
      end
      ST_OCW3: begin
        if (busDone) begin
          go        = 1'b1;
          goKind    = BUS_RD;
          stateNext = ST_RDREG;
        end
      end
      ST_RDREG: begin
        if (busDone) begin
          endRd     = 1'b1;
          stateNext = ST_READY;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Two-flop synchronizer for the PIC interrupt line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intMeta <= 1'b0;
      intS    <= 1'b0;
    end else begin
      intMeta <= pic.pic_int;
      intS    <= intMeta;
    end
  end

  // Pending request flags; a new request wins over a same-cycle grant so no pulse is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoiPend  <= 1'b0;
      rdPend   <= 1'b0;
      rdSelReg <= RD_SEL_IRR;
    end else if (startInit) begin
      eoiPend <= 1'b0;
      rdPend  <= 1'b0;
    end else begin
      if (grantEoi) eoiPend <= 1'b0;
      if (eoi_req && init_done && !autoEoi) eoiPend <= 1'b1;
      if (grantRd) rdPend <= 1'b0;
      if (rd_req && init_done && rd_sel != 2'd3 && (!rdPend || grantRd)) begin
        rdPend   <= 1'b1;
        rdSelReg <= rd_sel;
      end
    end
  end

  // Configuration capture and host-facing results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfgSngl     <= 1'b0;
      cfgIc4      <= 1'b0;
      cfgIcw2     <= 8'h00;
      cfgIcw3     <= 8'h00;
      cfgIcw4     <= 8'h00;
      cfgOcw1     <= 8'h00;
      init_done   <= 1'b0;
      vec_valid   <= 1'b0;
      vec         <= 8'h00;
      rdata_valid <= 1'b0;
      rdata       <= 8'h00;
    end else begin
      vec_valid   <= 1'b0;
      rdata_valid <= 1'b0;
      if (startInit) begin
        cfgSngl   <= icw1[1];
        cfgIc4    <= icw1[0];
        cfgIcw2   <= icw2;
        cfgIcw3   <= icw3;
        cfgIcw4   <= icw4;
        cfgOcw1   <= ocw1;
        init_done <= 1'b0;
      end
      if (endInit) init_done <= 1'b1;
      if (endVec) begin
        vec       <= captured;
        vec_valid <= 1'b1;
      end
      if (endRd) begin
        rdata       <= captured;
        rdata_valid <= 1'b1;
      end
    end
  end

endmodule
